// File: rtl/alu_md_unit_if.sv
// E-stage ALU bus: operand/opcode issue side and result/stall return side.
interface alu_md_unit_if #(
  parameter int WIDTH = 32
);
  logic             validE;
  logic             flushE;
  logic [4:0]       aluOpE;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] aluOutE;
  logic             stallE;

  modport master (
    output validE, flushE, aluOpE, SrcA, SrcB,
    input  aluOutE, stallE
  );

  modport slave (
    input  validE, flushE, aluOpE, SrcA, SrcB,
    output aluOutE, stallE
  );
endinterface

// File: rtl/alu_md_unit.sv
// Execute-stage ALU with iterative shift-add multiplier, restoring divider
// and HI/LO registers; multi-cycle ops hold the pipeline through stallE.
module alu_md_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic         clk,
  input logic         rst,
  alu_md_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic [WIDTH-1:0]   mag_b, hi, lo;
  logic               is_div, neg_res, neg_rem;

  logic               md_op, issue, last, mt_we, op_signed, sa, sb;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in, quot_fix, rem_fix;
  logic [WIDTH:0]     rem_sh, diff, mul_sum;
  logic [SHW-1:0]     shamt;

  assign md_op     = (bus.aluOpE[4:2] == 3'b011);
  assign op_signed = ~bus.aluOpE[0];
  assign sa        = op_signed & bus.SrcA[WIDTH-1];
  assign sb        = op_signed & bus.SrcB[WIDTH-1];
  assign mag_a_in  = sa ? -bus.SrcA : bus.SrcA;
  assign mag_b_in  = sb ? -bus.SrcB : bus.SrcB;
  assign last      = (cnt == SHW'(WIDTH - 1));
  assign shamt     = bus.SrcA[SHW-1:0];

  // FSM next state and stall
  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    bus.stallE = 1'b0;
    case (state)
      IDLE: begin
        issue = bus.validE & ~bus.flushE & md_op;
        bus.stallE = issue;
        if (issue) state_nxt = BUSY;
      end
      BUSY: begin
        bus.stallE = 1'b1;
        if (bus.flushE)  state_nxt = IDLE;
        else if (last)   state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign mt_we = bus.validE & ~bus.flushE & ~bus.stallE;

  // One iteration of the shared acc datapath: multiply keeps {partial, multiplier}
  // shifting right; divide keeps {remainder, quotient} shifting left.
  always_comb begin
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    rem_sh  = acc[2*WIDTH-1:WIDTH-1];
    diff    = rem_sh - {1'b0, mag_b};
    if (!is_div)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    prod_fix = neg_res ? -acc_step : acc_step;
    quot_fix = neg_res ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      mag_b   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state <= state_nxt;
      if (issue) begin
        acc     <= {{WIDTH{1'b0}}, mag_a_in};
        mag_b   <= mag_b_in;
        is_div  <= bus.aluOpE[1];
        // A zero divisor leaves the quotient all ones, so it is never negated.
        neg_res <= (sa ^ sb) & ~(bus.aluOpE[1] & (bus.SrcB == '0));
        neg_rem <= sa;
        cnt     <= '0;
      end else if (state == BUSY && !bus.flushE) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
        if (last) begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
      end
      if (mt_we && bus.aluOpE == 5'd18) hi <= bus.SrcA;
      if (mt_we && bus.aluOpE == 5'd19) lo <= bus.SrcA;
    end
  end

  always_comb begin
    bus.aluOutE = '0;
    case (bus.aluOpE)
      5'd0:  bus.aluOutE = bus.SrcA & bus.SrcB;
      5'd1:  bus.aluOutE = bus.SrcA - bus.SrcB;
      5'd2:  bus.aluOutE = bus.SrcA + bus.SrcB;
      5'd3:  bus.aluOutE = bus.SrcA ^ bus.SrcB;
      5'd4:  bus.aluOutE = ~(bus.SrcA | bus.SrcB);
      5'd5:  bus.aluOutE = bus.SrcA | bus.SrcB;
      5'd6:  bus.aluOutE = bus.SrcA;
      5'd7:  bus.aluOutE = {{(WIDTH-1){1'b0}}, $signed(bus.SrcA) < $signed(bus.SrcB)};
      5'd8:  bus.aluOutE = {{(WIDTH-1){1'b0}}, bus.SrcA < bus.SrcB};
      5'd9:  bus.aluOutE = bus.SrcB << shamt;
      5'd10: bus.aluOutE = bus.SrcB >> shamt;
      5'd11: bus.aluOutE = $unsigned($signed(bus.SrcB) >>> shamt);
      5'd16: bus.aluOutE = hi;
      5'd17: bus.aluOutE = lo;
      default: bus.aluOutE = '0;
    endcase
  end
endmodule

// File: tb/tb_alu_md_unit.sv
// Directed bench for alu_md_unit: combinational vector table plus
// multiply/divide, abort, reset and back-to-back sequences.
module tb_alu_md_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_md_unit_if #(.WIDTH(W)) bus ();
  alu_md_unit #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    string      name;
    logic [4:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the FSM idle; returns #1 after the DONE-cycle negedge.
  task automatic issue_md(input string name, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.validE = 1'b1;
    bus.aluOpE = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
    #1;
    chk({name, " out0"}, bus.aluOutE, 32'h0);
    while (bus.stallE && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    chk({name, " stall_cycles"}, 32'(n), 32'd33);
  endtask

  task automatic read_hilo(input string name, input logic [31:0] hi, input logic [31:0] lo);
    @(negedge clk);
    bus.validE = 1'b1;
    bus.aluOpE = 5'd16;
    #1 chk({name, " HI"}, bus.aluOutE, hi);
    bus.aluOpE = 5'd17;
    #1 chk({name, " LO"}, bus.aluOutE, lo);
    bus.validE = 1'b0;
  endtask

  initial begin
    vecs.push_back('{"AND",     5'd0,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0});
    vecs.push_back('{"SUB",     5'd1,  32'd5,        32'd7,        32'hFFFFFFFE});
    vecs.push_back('{"ADDwrap", 5'd2,  32'hFFFFFFFF, 32'd2,        32'h00000001});
    vecs.push_back('{"XOR",     5'd3,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555});
    vecs.push_back('{"NOR",     5'd4,  32'h0,        32'h0,        32'hFFFFFFFF});
    vecs.push_back('{"OR",      5'd5,  32'h000000F0, 32'h00000F00, 32'h00000FF0});
    vecs.push_back('{"PASSA",   5'd6,  32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF});
    vecs.push_back('{"SLT",     5'd7,  32'hFFFFFFFF, 32'd1,        32'd1});
    vecs.push_back('{"SLTU",    5'd8,  32'hFFFFFFFF, 32'd1,        32'd0});
    vecs.push_back('{"SLL",     5'd9,  32'd4,        32'h0000000F, 32'h000000F0});
    vecs.push_back('{"SLLmask", 5'd9,  32'd33,       32'd1,        32'd2});
    vecs.push_back('{"SRL",     5'd10, 32'd8,        32'h80000000, 32'h00800000});
    vecs.push_back('{"SRA",     5'd11, 32'd4,        32'h80000000, 32'hF8000000});
    vecs.push_back('{"SRApos",  5'd11, 32'h24,       32'h40000000, 32'h04000000});
    vecs.push_back('{"MULTout", 5'd12, 32'd3,        32'd4,        32'd0});
    vecs.push_back('{"MTHIout", 5'd18, 32'd3,        32'd4,        32'd0});
    vecs.push_back('{"OP25",    5'd25, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0});
    vecs.push_back('{"OP31",    5'd31, 32'hFFFFFFFF, 32'h1,        32'd0});

    rst = 1'b1;
    bus.validE = 1'b0;
    bus.flushE = 1'b0;
    bus.aluOpE = '0;
    bus.SrcA   = '0;
    bus.SrcB   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1 chk("reset stall", 32'(bus.stallE), 32'd0);
    read_hilo("reset", 32'h0, 32'h0);

    // validE low: no issue and no HI/LO side effects from the table
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.aluOpE = vecs[i].op;
      bus.SrcA   = vecs[i].a;
      bus.SrcB   = vecs[i].b;
      #1 chk(vecs[i].name, bus.aluOutE, vecs[i].exp);
    end
    read_hilo("table no side effect", 32'h0, 32'h0);

    @(negedge clk);
    issue_md("MULT", 5'd12, 32'hFFFFFFFF, 32'd2);
    read_hilo("MULT", 32'hFFFFFFFF, 32'hFFFFFFFE);
    @(negedge clk);
    issue_md("MULTU", 5'd13, 32'hFFFFFFFF, 32'd2);
    read_hilo("MULTU", 32'h00000001, 32'hFFFFFFFE);
    @(negedge clk);
    issue_md("MULTneg", 5'd12, 32'hFFFFFFFD, 32'd5);
    read_hilo("MULTneg", 32'hFFFFFFFF, 32'hFFFFFFF1);
    @(negedge clk);
    issue_md("DIV", 5'd14, 32'hFFFFFFF9, 32'd2);
    read_hilo("DIV", 32'hFFFFFFFF, 32'hFFFFFFFD);
    @(negedge clk);
    issue_md("DIVU0", 5'd15, 32'd7, 32'd0);
    read_hilo("DIVU0", 32'd7, 32'hFFFFFFFF);
    @(negedge clk);
    issue_md("DIV0neg", 5'd14, 32'hFFFFFFFB, 32'd0);
    read_hilo("DIV0neg", 32'hFFFFFFFB, 32'hFFFFFFFF);
    @(negedge clk);
    issue_md("DIVmin", 5'd14, 32'h80000000, 32'hFFFFFFFF);
    read_hilo("DIVmin", 32'h0, 32'h80000000);
    @(negedge clk);
    issue_md("DIVU", 5'd15, 32'd100, 32'd7);
    read_hilo("DIVU", 32'd2, 32'd14);

    // MTHI then a MULT flushed in BUSY cycle 10
    @(negedge clk);
    bus.validE = 1'b1;
    bus.aluOpE = 5'd18;
    bus.SrcA   = 32'h1234;
    @(negedge clk);
    bus.aluOpE = 5'd12;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd4;
    #1 chk("flush issue stall", 32'(bus.stallE), 32'd1);
    repeat (10) @(negedge clk);
    #1 chk("flush busy stall", 32'(bus.stallE), 32'd1);
    bus.flushE = 1'b1;
    @(negedge clk);
    bus.flushE = 1'b0;
    bus.validE = 1'b0;
    #1 chk("flush released", 32'(bus.stallE), 32'd0);
    bus.validE = 1'b1;
    bus.aluOpE = 5'd16;
    #1 chk("flush HI kept", bus.aluOutE, 32'h1234);
    bus.validE = 1'b0;

    // Reset in BUSY
    @(negedge clk);
    bus.validE = 1'b1;
    bus.aluOpE = 5'd13;
    bus.SrcA   = 32'd3;
    bus.SrcB   = 32'd5;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.validE = 1'b0;
    #1 chk("rst busy stall", 32'(bus.stallE), 32'd0);
    bus.aluOpE = 5'd16;
    #1 chk("rst busy HI", bus.aluOutE, 32'h0);
    bus.aluOpE = 5'd17;
    #1 chk("rst busy LO", bus.aluOutE, 32'h0);

    // Back-to-back MULTU, LO peeked during each DONE cycle
    @(negedge clk);
    issue_md("B2B first", 5'd13, 32'd3, 32'd5);
    bus.aluOpE = 5'd17;
    #1 chk("B2B first LO", bus.aluOutE, 32'd15);
    @(negedge clk);
    issue_md("B2B second", 5'd13, 32'd6, 32'd7);
    bus.aluOpE = 5'd17;
    #1 chk("B2B second LO", bus.aluOutE, 32'd42);
    bus.validE = 1'b0;
    @(negedge clk);
    #1 chk("B2B no reissue", 32'(bus.stallE), 32'd0);
    read_hilo("B2B final", 32'd0, 32'd42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
